pdn_power_sequencer: RTL

Parametrised power-up/power-down sequencer for N supply domains in the power distribution network. It drives one enable per domain in ascending index order on power-up and descending order on power-down. Each step waits for that domain's power-good, with a programmable settle time and a timeout. Any timeout or unexpected power-good loss latches a fault and sheds every domain at once. It sits between the chip-level power controller and the domain switches feeding the VDD rails.

---
 rtl/pdn_pkg.sv | 21 ++
 rtl/pdn_sync.sv | 26 ++
 rtl/pdn_power_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pdn_pkg.sv
// Shared types and defaults for the PDN power sequencer.
package pdn_pkg;

    typedef enum logic [2:0] {
        OFF,
        RAMP_UP,
        ON,
        RAMP_DN,
        FAULT
    } pdn_state_t;

    typedef enum logic {
        WAIT_PG,
        SETTLE_WAIT
    } pdn_phase_t;

    localparam int unsigned PDN_N_DOM_DEF   = 6;
    localparam int unsigned PDN_SETTLE_DEF  = 16;
    localparam int unsigned PDN_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/pdn_sync.sv
// Two-flop synchroniser for asynchronous status inputs.
module pdn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pdn_power_sequencer.sv
// Ordered power-up/power-down sequencer for N supply domains with
// per-step power-good wait, settle delay, timeout and supervision.
module pdn_power_sequencer
    import pdn_pkg::*;
#(
    parameter int N_DOM   = PDN_N_DOM_DEF,
    parameter int SETTLE  = PDN_SETTLE_DEF,
    parameter int TIMEOUT = PDN_TIMEOUT_DEF,
    parameter int IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1,
    parameter int CNT_W   = $clog2(((SETTLE > TIMEOUT) ? SETTLE : TIMEOUT) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_req,
    input  logic             dn_req,
    input  logic             fault_clr,
    input  logic [N_DOM-1:0] pgood,
    output logic [N_DOM-1:0] en,
    output logic             on,
    output logic             off,
    output logic             busy,
    output logic             fault,
    output logic [IDX_W-1:0] fault_dom
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

    pdn_state_t       state_q, state_d;
    pdn_phase_t       phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DOM-1:0] en_q, en_d;
    logic [IDX_W-1:0] fault_dom_q, fault_dom_d;
    logic             on_q, off_q, busy_q, fault_q;

    logic [N_DOM-1:0] pg_s;
    logic [N_DOM-1:0] sup_mask;
    logic             sup_hit;
    logic [IDX_W-1:0] sup_dom;

    pdn_sync #(.W(N_DOM)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pgood),
        .q_o (pg_s)
    );

    // Domains already proven good that have since lost power-good.
    always_comb begin
        sup_mask = '0;
        sup_dom  = '0;
        for (int j = 0; j < N_DOM; j++) begin
            sup_mask[j] = !pg_s[j] &&
                ((state_q == ON) ||
                 ((state_q == RAMP_UP) && (IDX_W'(j) < idx_q)));
        end
        for (int j = N_DOM - 1; j >= 0; j--) begin
            if (sup_mask[j]) begin
                sup_dom = IDX_W'(j);
            end
        end
        sup_hit = |sup_mask;
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        fault_dom_d = fault_dom_q;

        unique case (state_q)
            OFF: begin
                en_d = '0;
                if (up_req && !dn_req) begin
                    state_d = RAMP_UP;
                    phase_d = WAIT_PG;
                    idx_d   = '0;
                    cnt_d   = '0;
                    en_d[0] = 1'b1;
                end
            end

            RAMP_UP: begin
                if (sup_hit) begin
                    state_d     = FAULT;
                    phase_d     = WAIT_PG;
                    cnt_d       = '0;
                    en_d        = '0;
                    fault_dom_d = sup_dom;
                end else if (dn_req) begin
                    state_d     = RAMP_DN;
                    phase_d     = WAIT_PG;
                    cnt_d       = '0;
                    en_d[idx_q] = 1'b0;
                end else if (phase_q == WAIT_PG) begin
                    if (pg_s[idx_q]) begin
                        phase_d = SETTLE_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = FAULT;
                        cnt_d       = '0;
                        en_d        = '0;
                        fault_dom_d = idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == ST_LAST) begin
                    cnt_d   = '0;
                    phase_d = WAIT_PG;
                    if (idx_q == IDX_LAST) begin
                        state_d = ON;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        en_d[idx_d] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ON: begin
                en_d = '1;
                if (sup_hit) begin
                    state_d     = FAULT;
                    phase_d     = WAIT_PG;
                    cnt_d       = '0;
                    en_d        = '0;
                    fault_dom_d = sup_dom;
                end else if (dn_req) begin
                    state_d        = RAMP_DN;
                    phase_d        = WAIT_PG;
                    idx_d          = IDX_LAST;
                    cnt_d          = '0;
                    en_d[IDX_LAST] = 1'b0;
                end
            end

            RAMP_DN: begin
                if (phase_q == WAIT_PG) begin
                    if (!pg_s[idx_q]) begin
                        phase_d = SETTLE_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d     = FAULT;
                        cnt_d       = '0;
                        en_d        = '0;
                        fault_dom_d = idx_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q == ST_LAST) begin
                    cnt_d   = '0;
                    phase_d = WAIT_PG;
                    if (idx_q == '0) begin
                        state_d = OFF;
                        en_d    = '0;
                    end else begin
                        idx_d       = idx_q - 1'b1;
                        en_d[idx_d] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FAULT: begin
                en_d = '0;
                if (fault_clr && (pg_s == '0)) begin
                    state_d = OFF;
                    phase_d = WAIT_PG;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = OFF;
                phase_d = WAIT_PG;
                idx_d   = '0;
                cnt_d   = '0;
                en_d    = '0;
            end
        endcase
    end

    // Flags are registered from the next state so they move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OFF;
            phase_q     <= WAIT_PG;
            idx_q       <= '0;
            cnt_q       <= '0;
            en_q        <= '0;
            fault_dom_q <= '0;
            on_q        <= 1'b0;
            off_q       <= 1'b1;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            fault_dom_q <= fault_dom_d;
            on_q        <= (state_d == ON);
            off_q       <= (state_d == OFF);
            busy_q      <= (state_d == RAMP_UP) || (state_d == RAMP_DN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign en        = en_q;
    assign on        = on_q;
    assign off       = off_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign fault_dom = fault_dom_q;

endmodule
